// File: rtl/timer_oc_channel_if.sv
// Bus bundle between the timer core and one output-compare channel:
// counter/config inputs travel master->slave, waveform and status return.
interface timer_oc_channel_if #(
    parameter int WIDTH = 16
);
    logic             en;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] arr;
    logic             ccr_wr;
    logic [WIDTH-1:0] ccr_wdata;
    logic             preload_en;
    logic [2:0]       mode;
    logic             pol;
    logic             flag_clr;
    logic             oc_out;
    logic [WIDTH-1:0] ccr_active;
    logic             cc_flag;
    logic             uev;

    modport master (
        output en, count, arr, ccr_wr, ccr_wdata, preload_en, mode, pol, flag_clr,
        input  oc_out, ccr_active, cc_flag, uev
    );

    modport slave (
        input  en, count, arr, ccr_wr, ccr_wdata, preload_en, mode, pol, flag_clr,
        output oc_out, ccr_active, cc_flag, uev
    );
endinterface

// File: rtl/timer_oc_channel.sv
// Output-compare / PWM channel: compares the live timer count against a
// double-buffered CCR and drives a registered waveform, match flag and update pulse.
module timer_oc_channel #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    timer_oc_channel_if.slave    bus
);

    logic             oc_ref_q, oc_ref_d;
    logic             oc_out_q, oc_out_d;
    logic [WIDTH-1:0] ccr_preload_q, ccr_preload_d;
    logic [WIDTH-1:0] ccr_active_q, ccr_active_d;
    logic             cc_flag_q, cc_flag_d;
    logic             uev_q, uev_d;

    logic             wrap;
    logic             match;
    logic             below;

    always_comb begin
        wrap  = bus.en && (bus.count >= bus.arr);
        match = bus.en && (bus.count == ccr_active_q);
        below = (bus.count < ccr_active_q);

        ccr_preload_d = ccr_preload_q;
        if (bus.ccr_wr) begin
            ccr_preload_d = bus.ccr_wdata;
        end

        // A buffered write coinciding with wrap must not bypass the shadow:
        // the active value takes the preload as it stood before this edge.
        ccr_active_d = ccr_active_q;
        if (bus.ccr_wr && !bus.preload_en) begin
            ccr_active_d = bus.ccr_wdata;
        end else if (wrap && bus.preload_en) begin
            ccr_active_d = ccr_preload_q;
        end

        oc_ref_d = oc_ref_q;
        case (bus.mode)
            3'b000: oc_ref_d = oc_ref_q;
            3'b001: if (match) oc_ref_d = 1'b1;
            3'b010: if (match) oc_ref_d = 1'b0;
            3'b011: if (match) oc_ref_d = ~oc_ref_q;
            3'b100: oc_ref_d = 1'b0;
            3'b101: oc_ref_d = 1'b1;
            3'b110: if (bus.en) oc_ref_d = below;
            3'b111: if (bus.en) oc_ref_d = ~below;
            default: oc_ref_d = oc_ref_q;
        endcase

        oc_out_d  = oc_ref_d ^ bus.pol;
        cc_flag_d = match | (cc_flag_q & ~bus.flag_clr);
        uev_d     = wrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oc_ref_q      <= 1'b0;
            oc_out_q      <= 1'b0;
            ccr_preload_q <= '0;
            ccr_active_q  <= '0;
            cc_flag_q     <= 1'b0;
            uev_q         <= 1'b0;
        end else begin
            oc_ref_q      <= oc_ref_d;
            oc_out_q      <= oc_out_d;
            ccr_preload_q <= ccr_preload_d;
            ccr_active_q  <= ccr_active_d;
            cc_flag_q     <= cc_flag_d;
            uev_q         <= uev_d;
        end
    end

    assign bus.oc_out     = oc_out_q;
    assign bus.ccr_active = ccr_active_q;
    assign bus.cc_flag    = cc_flag_q;
    assign bus.uev        = uev_q;

endmodule

// File: tb/tb_timer_oc_channel.sv
// Directed bench for timer_oc_channel: the bench plays the timer counter
// and compares captured per-period waveforms against hand-derived patterns.
module tb_timer_oc_channel;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    timer_oc_channel_if #(.WIDTH(W)) bus ();

    timer_oc_channel #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [9:0] op, up, fp;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock; the bench's counter advances just after the edge like the real timer.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.en) bus.count = (bus.count >= bus.arr) ? 16'd0 : bus.count + 16'd1;
    endtask

    // Direct CCR write with the channel idle; also clears the flag.
    task automatic write_idle(input logic [W-1:0] val);
        bus.en         = 1'b0;
        bus.ccr_wr     = 1'b1;
        bus.ccr_wdata  = val;
        bus.preload_en = 1'b0;
        bus.flag_clr   = 1'b1;
        tick();
        bus.ccr_wr     = 1'b0;
        bus.flag_clr   = 1'b0;
    endtask

    // Ten enabled cycles from count 0 (arr=9); bit k = output after the edge at count k.
    task automatic run_period(input int wr_at, input logic [W-1:0] wv, input int clr_at,
                              output logic [9:0] o_pat, output logic [9:0] u_pat,
                              output logic [9:0] f_pat);
        o_pat = '0; u_pat = '0; f_pat = '0;
        for (int k = 0; k < 10; k++) begin
            bus.ccr_wr    = (k == wr_at);
            bus.ccr_wdata = wv;
            bus.flag_clr  = (k == clr_at);
            tick();
            bus.ccr_wr    = 1'b0;
            bus.flag_clr  = 1'b0;
            o_pat[k] = bus.oc_out;
            u_pat[k] = bus.uev;
            f_pat[k] = bus.cc_flag;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.en = 1'b0; bus.count = '0; bus.arr = '0; bus.ccr_wr = 1'b0; bus.ccr_wdata = '0;
        bus.preload_en = 1'b0; bus.mode = 3'b000; bus.pol = 1'b0; bus.flag_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_oc_out", bus.oc_out, 0);
        chk("rst_ccr_active", bus.ccr_active, 0);
        chk("rst_cc_flag", bus.cc_flag, 0);
        chk("rst_uev", bus.uev, 0);

        // PWM1, arr=9, ccr=3
        bus.arr = 16'd9; bus.mode = 3'b110; bus.pol = 1'b0;
        write_idle(16'd3);
        chk("direct_write_active", bus.ccr_active, 3);
        bus.count = '0; bus.en = 1'b1;
        run_period(-1, 0, -1, op, up, fp);
        chk("pwm1_duty3_p1", op, 10'b0000000111);
        chk("pwm1_uev_p1", up, 10'b1000000000);
        chk("pwm1_flag_at_match", fp, 10'b1111111000);
        run_period(-1, 0, -1, op, up, fp);
        chk("pwm1_duty3_p2", op, 10'b0000000111);
        chk("pwm1_uev_p2", up, 10'b1000000000);

        bus.pol = 1'b1;
        run_period(-1, 0, -1, op, up, fp);
        chk("pwm1_pol1_inverse", op, 10'b1111111000);

        bus.pol = 1'b0;
        write_idle(16'd0);
        bus.en = 1'b1;
        run_period(-1, 0, -1, op, up, fp);
        chk("pwm1_ccr0_low", op, 10'b0000000000);
        write_idle(16'd12);
        bus.en = 1'b1;
        run_period(-1, 0, -1, op, up, fp);
        chk("pwm1_ccr12_high", op, 10'b1111111111);

        // Preloaded CCR changes
        write_idle(16'd3);
        bus.preload_en = 1'b1; bus.en = 1'b1;
        run_period(5, 16'd6, -1, op, up, fp);
        chk("preload_mid_keep3", op, 10'b0000000111);
        chk("preload_loaded6", bus.ccr_active, 6);
        run_period(9, 16'd3, -1, op, up, fp);
        chk("preload_duty6", op, 10'b0000111111);
        chk("preload_wrap_write_old", bus.ccr_active, 6);
        run_period(-1, 0, -1, op, up, fp);
        chk("preload_duty6_again", op, 10'b0000111111);
        chk("preload_loaded3", bus.ccr_active, 3);
        run_period(-1, 0, -1, op, up, fp);
        chk("preload_duty3", op, 10'b0000000111);

        // Toggle mode, ccr=4
        bus.mode = 3'b011;
        write_idle(16'd4);
        chk("toggle_flag_cleared", bus.cc_flag, 0);
        bus.en = 1'b1;
        run_period(-1, 0, 4, op, up, fp);
        chk("toggle_p1", op, 10'b1111110000);
        chk("toggle_set_wins_clr", fp, 10'b1111110000);
        run_period(-1, 0, -1, op, up, fp);
        chk("toggle_p2", op, 10'b0000001111);

        // Disable mid-period in PWM1
        bus.mode = 3'b110;
        write_idle(16'd2);
        bus.en = 1'b1;
        tick(); tick();
        chk("frz_pre_oc_out", bus.oc_out, 1);
        bus.en = 1'b0; bus.arr = 16'd2;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("frz_oc_out", bus.oc_out, 1);
            chk("frz_cc_flag", bus.cc_flag, 0);
            chk("frz_uev", bus.uev, 0);
        end
        bus.mode = 3'b100;
        tick();
        chk("force0_disabled", bus.oc_out, 0);
        bus.mode = 3'b101;
        tick();
        chk("force1_disabled", bus.oc_out, 1);

        // Async reset mid-period
        bus.arr = 16'd9; bus.mode = 3'b001; bus.count = '0; bus.en = 1'b1;
        repeat (5) tick();
        chk("pre_rst_oc_out", bus.oc_out, 1);
        chk("pre_rst_cc_flag", bus.cc_flag, 1);
        chk("pre_rst_count", bus.count, 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_oc_out", bus.oc_out, 0);
        chk("async_rst_cc_flag", bus.cc_flag, 0);
        chk("async_rst_uev", bus.uev, 0);
        chk("async_rst_ccr_active", bus.ccr_active, 0);
        @(negedge clk);
        rst_n = 1'b1; bus.en = 1'b0; bus.count = '0;
        tick();
        chk("post_rst_ccr_active", bus.ccr_active, 0);

        // arr=0: wrap every enabled cycle
        bus.arr = '0; bus.mode = 3'b110; bus.en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("arr0_uev_high", bus.uev, 1);
        end
        chk("arr0_match_flag", bus.cc_flag, 1);
        chk("arr0_pwm_low", bus.oc_out, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
